// File: rtl/rx_pkt_ingress_pkg.sv
// Shared definitions for the router-to-accelerator ingress stage:
// packet field offsets, the data-packet kind code and the issue FSM states.
package rx_pkt_ingress_pkg;

   // Packet field boundaries (bit positions within the 128-bit packet)
   localparam int KIND_MSB    = 127;
   localparam int KIND_LSB    = 123;
   localparam int OP_MSB      = 122;
   localparam int OP_LSB      = 120;
   localparam int HDR_MSB     = 119;
   localparam int HDR_LSB     = 88;
   localparam int PAYLOAD_MSB = 87;
   localparam int PAYLOAD_LSB = 56;
   localparam int ADDR_MSB    = 10;
   localparam int ADDR_LSB    = 0;

   // Kind code that marks a packet destined for the matching accelerator
   localparam logic [4:0] KIND_DATA = 5'b10000;

   // Issue FSM states; prefixed so they never collide with the GAP parameter
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

endpackage

// File: rtl/rx_pkt_ingress_pkt_fifo.sv
// Synchronous FIFO holding buffered data packets. The head entry is always
// visible on head so the issue logic can capture it into its output register.
module rx_pkt_ingress_pkt_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 128
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          do_push;
   logic          do_pop;

   // Guard against overflow/underflow even if a caller misbehaves
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage array: written only, never reset (contents are don't-care when empty)
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign count = count_reg;
   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign empty = (count_reg == '0);

endmodule

// File: rtl/rx_pkt_ingress.sv
// Ingress stage between the router and the message-matching accelerator.
// Filters non-data packets (counting them), buffers data packets, and
// issues them as single-cycle strobes spaced GAP cycles apart because the
// accelerator cannot apply backpressure.
module rx_pkt_ingress
   import rx_pkt_ingress_pkg::*;
#(
   parameter int         DEPTH     = 8,
   parameter int         PKT_W     = 128,
   parameter int         GAP       = 16,
   parameter logic [4:0] DATA_KIND = KIND_DATA
) (
   input  logic                       nios_clk,
   input  logic                       reset,
   input  logic [PKT_W-1:0]           rtr_pkt,
   input  logic                       rtr_valid,
   output logic                       rtr_ready,
   input  logic                       acc_hold,
   output logic [PKT_W-1:0]           packet_in,
   output logic                       packet_in_valid,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic [15:0]                drop_cnt
);

   localparam int GCNT_W = $clog2(GAP) + 1;
   // Cycle budget: ISSUE(1) + GAP-state cycles + IDLE(1) = GAP under backlog
   localparam logic [GCNT_W-1:0] GAP_LOAD = GCNT_W'(GAP - 2);

   state_t                  state_reg;
   logic [GCNT_W-1:0]       gap_cnt_reg;
   logic [15:0]             drop_cnt_reg;
   logic [PKT_W-1:0]        fifo_head;
   logic [$clog2(DEPTH):0]  fifo_count;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    handshake;
   logic                    is_data;
   logic                    push;
   logic                    pop;

   assign rtr_ready = !reset && !fifo_full;
   assign handshake = rtr_valid && rtr_ready;
   assign is_data   = (rtr_pkt[KIND_MSB:KIND_LSB] == DATA_KIND);
   assign push      = handshake && is_data;
   // The head is consumed in the same cycle it is captured into packet_in
   assign pop       = (state_reg == ST_ISSUE);

   rx_pkt_ingress_pkt_fifo #(
      .DEPTH (DEPTH),
      .W     (PKT_W)
   ) u_fifo (
      .clk       (nios_clk),
      .rst       (reset),
      .push      (push),
      .push_data (rtr_pkt),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Issue FSM: wait for a buffered packet, strobe it out, then enforce spacing
   always_ff @(posedge nios_clk or posedge reset) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         gap_cnt_reg     <= '0;
         packet_in       <= '0;
         packet_in_valid <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               packet_in_valid <= 1'b0;
               if (!fifo_empty && !acc_hold) begin
                  state_reg <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               packet_in       <= fifo_head;
               packet_in_valid <= 1'b1;
               gap_cnt_reg     <= GAP_LOAD;
               state_reg       <= ST_GAP;
            end
            ST_GAP: begin
               packet_in_valid <= 1'b0;
               // Leave when the decremented count would reach zero
               if (gap_cnt_reg <= GCNT_W'(1)) begin
                  gap_cnt_reg <= '0;
                  state_reg   <= ST_IDLE;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - GCNT_W'(1);
               end
            end
            default: begin
               packet_in_valid <= 1'b0;
               state_reg       <= ST_IDLE;
            end
         endcase
      end
   end

   // Saturating count of discarded non-data packets
   always_ff @(posedge nios_clk or posedge reset) begin
      if (reset) begin
         drop_cnt_reg <= '0;
      end else if (handshake && !is_data && (drop_cnt_reg != 16'hFFFF)) begin
         drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
   end

   assign drop_cnt   = drop_cnt_reg;
   assign fifo_level = fifo_count;

endmodule

// File: tb/tb_rx_pkt_ingress.sv
// Self-checking bench for rx_pkt_ingress: reset, table-driven single packets,
// hand-written timing sequences and a randomized run against a queue model.
module tb_rx_pkt_ingress;

   localparam int         DEPTH  = 8;
   localparam int         PKT_W  = 128;
   localparam int         GAP    = 16;
   localparam logic [4:0] KIND_D = 5'b10000;

   logic               clk       = 1'b0;
   logic               reset     = 1'b1;
   logic [PKT_W-1:0]   rtr_pkt   = '0;
   logic               rtr_valid = 1'b0;
   logic               acc_hold  = 1'b0;
   logic               rtr_ready;
   logic [PKT_W-1:0]   packet_in;
   logic               packet_in_valid;
   logic [3:0]         fifo_level;
   logic [15:0]        drop_cnt;

   int                 n_checks = 0;
   int                 n_pass   = 0;
   int                 cyc      = 0;
   logic [PKT_W-1:0]   pq[$];
   int                 pt[$];
   logic [15:0]        exp_drop = '0;

   rx_pkt_ingress #(
      .DEPTH     (DEPTH),
      .PKT_W     (PKT_W),
      .GAP       (GAP),
      .DATA_KIND (KIND_D)
   ) dut (
      .nios_clk        (clk),
      .reset           (reset),
      .rtr_pkt         (rtr_pkt),
      .rtr_valid       (rtr_valid),
      .rtr_ready       (rtr_ready),
      .acc_hold        (acc_hold),
      .packet_in       (packet_in),
      .packet_in_valid (packet_in_valid),
      .fifo_level      (fifo_level),
      .drop_cnt        (drop_cnt)
   );

   always #5 clk = ~clk;

   // Pulse logger: counts edges and records every issue strobe with its edge index
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (packet_in_valid) begin
         pq.push_back(packet_in);
         pt.push_back(cyc);
      end
   end

   typedef struct {
      logic [4:0]  kind;
      logic [2:0]  op;
      logic [31:0] hdr;
      logic [31:0] pay;
      logic [10:0] addr;
      bit          exp_issue;
   } vec_t;

   vec_t vt[7];

   function automatic logic [127:0] mk(input logic [4:0] k, input logic [2:0] op,
                                       input logic [31:0] hdr, input logic [31:0] pay,
                                       input logic [10:0] addr);
      return {k, op, hdr, pay, 45'b0, addr};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic bump_drop();
      if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
   endtask

   // Present a packet and hold it until accepted; returns the accepting edge index
   task automatic send_pkt(input logic [127:0] p, output int acc_cyc);
      acc_cyc   = -1;
      rtr_pkt   = p;
      rtr_valid = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (rtr_ready) begin
            @(negedge clk);
            acc_cyc   = cyc;
            rtr_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      rtr_valid = 1'b0;
      n_checks++;
      $display("FAIL send_timeout: rtr_ready stayed 0, expected 1 within 3000 cycles");
   endtask

   initial begin
      logic [127:0] p;
      logic [127:0] hp[9];
      logic [127:0] dp;
      logic [127:0] rnd;
      logic [4:0]   k;
      int           ac;
      int           bad;
      int           mlevel;
      int           last_pulse;
      bit           dacc;
      bit           dv;
      logic [127:0] eq[$];

      vt[0] = '{5'b10000, 3'b111, 32'h00010002, 32'h55555555, 11'h000, 1'b1};
      vt[1] = '{5'b01000, 3'b001, 32'h00030201, 32'h11111111, 11'h001, 1'b0};
      vt[2] = '{5'b10000, 3'b000, 32'hDEADBEEF, 32'h12345678, 11'h7FF, 1'b1};
      vt[3] = '{5'b00000, 3'b010, 32'h00000000, 32'h00000000, 11'h000, 1'b0};
      vt[4] = '{5'b11111, 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 11'h7FF, 1'b0};
      vt[5] = '{5'b10001, 3'b011, 32'h00030205, 32'hA5A5A5A5, 11'h123, 1'b0};
      vt[6] = '{5'b10000, 3'b101, 32'hFFFFFFFF, 32'h00000000, 11'h400, 1'b1};

      // ---- reset held for 3 edges ----
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_valid", packet_in_valid, 0);
         chk("rst_pkt", packet_in, 0);
         chk("rst_level", fifo_level, 0);
         chk("rst_drop", drop_cnt, 0);
         chk("rst_ready", rtr_ready, 0);
      end
      reset = 1'b0;
      #1;
      chk("rel_ready", rtr_ready, 1);
      chk("rel_level", fifo_level, 0);
      @(negedge clk);

      // ---- table-driven single packets ----
      for (int v = 0; v < 7; v++) begin
         p = mk(vt[v].kind, vt[v].op, vt[v].hdr, vt[v].pay, vt[v].addr);
         pq.delete(); pt.delete();
         send_pkt(p, ac);
         if (!vt[v].exp_issue) bump_drop();
         repeat (GAP + 6) @(negedge clk);
         chk("tbl_issue_cnt", pq.size(), vt[v].exp_issue);
         if (vt[v].exp_issue && pq.size() > 0) chk("tbl_pkt", pq[0], p);
         chk("tbl_drop", drop_cnt, exp_drop);
         chk("tbl_level", fifo_level, 0);
         $display("vec %0d kind=%b issued=%0d drop_cnt=%0d", v, vt[v].kind, pq.size(), drop_cnt);
      end

      // ---- single packet latency and hold-after-pulse ----
      p = mk(5'b10000, 3'b111, 32'h00010002, 32'h55555555, 11'h000);
      pq.delete(); pt.delete();
      send_pkt(p, ac);
      chk("lat_level_after_accept", fifo_level, 1);
      @(negedge clk); @(negedge clk);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (packet_in !== p || packet_in_valid !== 1'b0) bad++;
      end
      chk("lat_pulse_cnt", pq.size(), 1);
      if (pt.size() > 0) chk("lat_edges", pt[0] - ac, 2);
      chk("lat_stable", bad, 0);
      chk("lat_level", fifo_level, 0);
      $display("single: accept edge %0d, pulses %0d", ac, pq.size());

      // ---- three back-to-back data packets ----
      hp[0] = mk(5'b10000, 3'b001, 32'h00010002, 32'h0000AAAA, 11'h010);
      hp[1] = mk(5'b10000, 3'b010, 32'h00030201, 32'h0000BBBB, 11'h020);
      hp[2] = mk(5'b10000, 3'b011, 32'h00030205, 32'h0000CCCC, 11'h030);
      pq.delete(); pt.delete();
      for (int i = 0; i < 3; i++) send_pkt(hp[i], ac);
      repeat (60) @(negedge clk);
      chk("b2b_cnt", pq.size(), 3);
      if (pq.size() == 3) begin
         for (int i = 0; i < 3; i++) chk("b2b_order", pq[i], hp[i]);
         chk("b2b_space01", pt[1] - pt[0], GAP);
         chk("b2b_space12", pt[2] - pt[1], GAP);
      end
      $display("b2b: pulses %0d", pq.size());

      // ---- acc_hold with a full FIFO and a stalled 9th packet ----
      for (int i = 0; i < 9; i++)
         hp[i] = mk(5'b10000, 3'(i), 32'h00100000 + 32'(i), 32'($urandom), 11'(i));
      pq.delete(); pt.delete();
      acc_hold = 1'b1;
      for (int i = 0; i < 8; i++) send_pkt(hp[i], ac);
      chk("hold_ready_full", rtr_ready, 0);
      chk("hold_level_full", fifo_level, 8);
      rtr_pkt   = hp[8];
      rtr_valid = 1'b1;
      repeat (5) @(negedge clk);
      chk("hold_stall_ready", rtr_ready, 0);
      chk("hold_stall_level", fifo_level, 8);
      chk("hold_no_pulse", pq.size(), 0);
      acc_hold = 1'b0;
      send_pkt(hp[8], ac);
      repeat (9 * GAP + 20) @(negedge clk);
      chk("hold_cnt", pq.size(), 9);
      if (pq.size() == 9) begin
         bad = 0;
         for (int i = 0; i < 9; i++) chk("hold_order", pq[i], hp[i]);
         for (int i = 1; i < 9; i++) if (pt[i] - pt[i-1] != GAP) bad++;
         chk("hold_spacing", bad, 0);
      end
      $display("hold: pulses %0d", pq.size());

      // ---- randomized traffic against a queue model ----
      mlevel = 0; last_pulse = -1000; dacc = 0; dp = '0;
      for (int c = 0; c < 1700; c++) begin
         if (dacc) begin
            if (dp[127:123] == KIND_D) begin
               eq.push_back(dp);
               mlevel++;
            end else begin
               bump_drop();
            end
         end
         if (packet_in_valid) begin
            if (eq.size() == 0) begin
               n_checks++;
               $display("FAIL rnd_spurious: got pulse %h, expected no pulse (model empty)", packet_in);
            end else begin
               chk("rnd_order", packet_in, eq.pop_front());
               mlevel--;
            end
            chk("rnd_spacing_ok", (cyc - last_pulse) >= GAP, 1);
            last_pulse = cyc;
         end
         chk("rnd_level", fifo_level, mlevel);
         chk("rnd_drop", drop_cnt, exp_drop);
         chk("rnd_ready", rtr_ready, mlevel < DEPTH);
         if (c < 1500) begin
            if ($urandom_range(0, 19) == 0) acc_hold = ($urandom_range(0, 3) == 0);
            dv  = ($urandom_range(0, 2) != 0);
            rnd = {$urandom, $urandom, $urandom, $urandom};
            k   = 5'($urandom);
            if (k == KIND_D) k = 5'b00001;
            if ($urandom_range(0, 9) < 6) k = KIND_D;
            dp = {k, rnd[122:0]};
         end else begin
            acc_hold = 1'b0;
            dv = 1'b0;
         end
         rtr_pkt   = dp;
         rtr_valid = dv;
         dacc      = dv && (mlevel < DEPTH);
         @(negedge clk);
      end
      rtr_valid = 1'b0;
      chk("rnd_drained", eq.size(), 0);
      $display("random: drop_cnt=%0d level=%0d", drop_cnt, fifo_level);

      // ---- non-data packet and drop counter saturation ----
      pq.delete(); pt.delete();
      p = mk(5'b01000, 3'b000, 32'h00010002, 32'h0, 11'h0);
      send_pkt(p, ac);
      bump_drop();
      repeat (40) @(negedge clk);
      chk("drop_one", drop_cnt, exp_drop);
      chk("drop_no_pulse", pq.size(), 0);
      chk("drop_level", fifo_level, 0);
      rtr_pkt   = p;
      rtr_valid = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         @(negedge clk);
         bump_drop();
      end
      rtr_valid = 1'b0;
      chk("drop_sat_model", drop_cnt, exp_drop);
      chk("drop_sat", drop_cnt, 16'hFFFF);
      $display("saturation: drop_cnt=%h", drop_cnt);

      // ---- reset while in the gap after the first pulse ----
      for (int i = 0; i < 3; i++) send_pkt(hp[i], ac);
      pq.delete(); pt.delete();
      for (int i = 0; i < 50 && pq.size() == 0; i++) @(negedge clk);
      chk("rstg_first_pulse", pq.size(), 1);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rstg_valid", packet_in_valid, 0);
      chk("rstg_level", fifo_level, 0);
      chk("rstg_pkt", packet_in, 0);
      chk("rstg_drop", drop_cnt, 0);
      chk("rstg_ready", rtr_ready, 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      pq.delete(); pt.delete();
      repeat (100) @(negedge clk);
      chk("rstg_quiet", pq.size(), 0);
      chk("rstg_level_after", fifo_level, 0);
      $display("reset-in-gap: pulses after release %0d", pq.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rx_pkt_ingress.md
Name: rx_pkt_ingress

Overview:
- Network-side ingress stage that sits directly upstream of the message-matching receive accelerator.
- Accepts 128-bit packets from the router over a valid/ready handshake, filters out non-data packets, and buffers data packets in a small FIFO.
- Issues buffered packets to the accelerator's packet_in/packet_in_valid pair as single-cycle valid pulses, spaced so matching logic is never overrun (the accelerator has no ready).

Parameters:
- DEPTH, 8, FIFO entries; power of two, min 2.
- PKT_W, 128, packet width.
- GAP, 16, min cycles between consecutive packet_in_valid pulses; min 2.
- DATA_KIND, 5'b10000, packet kind field value that marks a data packet.

Ports:
- nios_clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- rtr_pkt  in  PKT_W  packet from router.
- rtr_valid  in  1  rtr_pkt valid.
- rtr_ready  out  1  ingress can accept.
- acc_hold  in  1  accelerator requests no new issue.
- packet_in  out  PKT_W  packet to accelerator.
- packet_in_valid  out  1  one-cycle issue strobe.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  out  16  non-data packets discarded, saturating.

Behaviour:
- Packet fields:
  - [127:123] kind.
  - [122:120] opcode.
  - [119:88] header: comm/tag/src/dst bytes.
  - [87:56] payload.
  - [55:11] reserved.
  - [10:0] addr.
  - The ingress stage never alters field contents.
- Reset, asynchronous: FIFO pointers and count cleared; FSM to IDLE; packet_in=0, packet_in_valid=0, drop_cnt=0, fifo_level=0. rtr_ready=0 while reset is asserted.
- rtr_ready = !reset && (count < DEPTH), combinational from the registered count.
- Handshake: a transfer occurs on an edge where rtr_valid && rtr_ready.
  - kind==DATA_KIND: push into FIFO.
  - Otherwise: discard and increment drop_cnt, holding at 16'hFFFF.
  - Dropped packets consume the handshake normally.
- FSM states:
  - IDLE: if count>0 && !acc_hold, go to ISSUE on the next edge. acc_hold is sampled only in IDLE.
  - ISSUE (exactly one cycle): packet_in <= FIFO head, packet_in_valid=1, pop head, gap counter <= GAP-2, next state GAP.
  - GAP: packet_in_valid=0; decrement counter; go to IDLE when counter==0.
  - Result: consecutive pulses are exactly GAP cycles apart under continuous backlog with acc_hold=0.
- packet_in is registered and holds its value after the pulse until the next ISSUE. The accelerator may sample it late.
- Latency: packet accepted on edge E into an empty FIFO, FSM in IDLE, acc_hold=0 → packet_in_valid high for the cycle after edge E+2.
- Simultaneous push and pop: count unchanged; the head pops first.
  - Push into a full FIFO cannot happen because ready is low.
  - Pop from an empty FIFO cannot happen because IDLE checks count.
- Pointers wrap modulo DEPTH. Order is strict FIFO.
- Reset mid-GAP or mid-ISSUE: the in-flight pulse is truncated and buffered packets are discarded. No pulse occurs after reset deasserts until new packets arrive.
- fifo_level equals the registered count.

Decomposition:
- Shared package holds:
  - Packet field offset constants (KIND_MSB/LSB, OP, HDR, PAYLOAD, ADDR).
  - DATA_KIND.
  - FSM state enum {IDLE, ISSUE, GAP}.
- One natural sub-module: pkt_fifo, a synchronous FIFO with count, full, empty, sized DEPTH×PKT_W. rx_pkt_ingress holds the filter, FSM, gap counter and drop counter.

Test Plan:
- Reset: assert reset for 3 edges → all outputs 0, rtr_ready=0. Deassert → rtr_ready=1, fifo_level=0.
- Single packet {5'b10000,3'b111,32'h00010002,32'h55555555,45'b0,11'h000}, one-cycle valid → packet_in_valid pulse 2 edges later; packet_in equals the packet and stays stable 40 cycles; fifo_level returns to 0.
- Three back-to-back data packets with headers 32'h00010002, 32'h00030201, 32'h00030205, GAP=16 → three pulses exactly 16 cycles apart, order preserved.
- acc_hold=1, push 9 packets → rtr_ready drops after the 8th acceptance, fifo_level=8, 9th stalled with rtr_valid held. Release hold → 9th accepted after the first pop; all 9 issued in order.
- Packet with kind 5'b01000 → accepted (ready high), no packet_in_valid, drop_cnt=1, fifo_level=0. Send 70000 such packets → drop_cnt=16'hFFFF.
- Push 3 packets, assert reset 4 cycles after the first pulse (inside GAP) → packet_in_valid=0, fifo_level=0. No further pulses for 100 cycles after deassert.
